// File: rtl/hamming_enc_seq.sv
// Hamming (16,11) SECDED encode sequencer: reads NUM_MSG byte-pair messages, writes encoded words back.
// Optional macro HAMMING_ENC_SEQ_BADIN_EN adds Bad_cnt, a count of messages with nonzero unused high bits.
module hamming_enc_seq #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] Mem_addr,
    input  logic [7:0]    Mem_rdata,
    output logic          Mem_we,
    output logic [7:0]    Mem_wdata
`ifdef HAMMING_ENC_SEQ_BADIN_EN
    ,
    output logic [3:0]    Bad_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [11:1] d_q, d_d;
    logic [15:0] enc;
    logic        start_ok;
    logic        last_msg;

    function automatic logic [15:0] encode(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

    assign enc      = encode(d_q);
    assign start_ok = Start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_msg = (idx_q == 7'(NUM_MSG - 1));

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        d_d     = d_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d = S_RD_LO;
                    idx_d   = '0;
                end
            end
            S_RD_LO: begin
                d_d[8:1] = Mem_rdata;
                state_d  = S_RD_HI;
            end
            S_RD_HI: begin
                d_d[11:9] = Mem_rdata[2:0];
                state_d   = S_WR_LO;
            end
            S_WR_LO: state_d = S_WR_HI;
            S_WR_HI: begin
                if (last_msg) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    state_d = S_RD_LO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory-side outputs depend only on registered state, so Start never reaches them combinationally.
    always_comb begin
        Busy      = 1'b0;
        Done      = 1'b0;
        Mem_addr  = '0;
        Mem_we    = 1'b0;
        Mem_wdata = '0;
        unique case (state_q)
            S_RD_LO: begin
                Busy     = 1'b1;
                Mem_addr = AW'(SRC_BASE + 2 * int'(idx_q));
            end
            S_RD_HI: begin
                Busy     = 1'b1;
                Mem_addr = AW'(SRC_BASE + 2 * int'(idx_q) + 1);
            end
            S_WR_LO: begin
                Busy      = 1'b1;
                Mem_addr  = AW'(DST_BASE + 2 * int'(idx_q));
                Mem_we    = 1'b1;
                Mem_wdata = enc[7:0];
            end
            S_WR_HI: begin
                Busy      = 1'b1;
                Mem_addr  = AW'(DST_BASE + 2 * int'(idx_q) + 1);
                Mem_we    = 1'b1;
                Mem_wdata = enc[15:8];
            end
            S_DONE:  Done = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            d_q     <= d_d;
        end
    end

`ifdef HAMMING_ENC_SEQ_BADIN_EN
    logic [3:0] bad_q, bad_d;

    always_comb begin
        bad_d = bad_q;
        if (start_ok) begin
            bad_d = '0;
        end else if (state_q == S_RD_HI && |Mem_rdata[7:3] && bad_q != 4'hF) begin
            bad_d = bad_q + 4'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bad_q <= '0;
        end else begin
            bad_q <= bad_d;
        end
    end

    assign Bad_cnt = bad_q;
`else
    logic unused_rdata_hi;
    logic unused_start_ok;
    assign unused_rdata_hi = ^Mem_rdata[7:3];
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Self-checking bench for hamming_enc_seq: byte memory model plus positional Hamming reference.
// Define HAMMING_ENC_SEQ_BADIN_EN to also check Bad_cnt.
module tb_hamming_enc_seq;

    localparam int NUM_MSG  = 15;
    localparam int SRC_BASE = 0;
    localparam int DST_BASE = 30;
    localparam int AW       = 8;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic          Busy;
    logic          Done;
    logic [AW-1:0] Mem_addr;
    logic [7:0]    Mem_rdata;
    logic          Mem_we;
    logic [7:0]    Mem_wdata;
`ifdef HAMMING_ENC_SEQ_BADIN_EN
    logic [3:0]    Bad_cnt;
`endif

    logic [7:0]    mem [256];
    logic          tb_we = 1'b0;
    logic [7:0]    tb_addr = '0;
    logic [7:0]    tb_wdata = '0;

    logic [15:0]   src_word [NUM_MSG];
    int            exp_bad;
    int            vectors = 0;
    int            miscompares = 0;

    hamming_enc_seq #(
        .NUM_MSG (NUM_MSG),
        .SRC_BASE(SRC_BASE),
        .DST_BASE(DST_BASE),
        .AW      (AW)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Busy     (Busy),
        .Done     (Done),
        .Mem_addr (Mem_addr),
        .Mem_rdata(Mem_rdata),
        .Mem_we   (Mem_we),
        .Mem_wdata(Mem_wdata)
`ifdef HAMMING_ENC_SEQ_BADIN_EN
        ,
        .Bad_cnt  (Bad_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    assign Mem_rdata = mem[Mem_addr];

    always @(posedge Clk) begin
        if (Mem_we) mem[Mem_addr] <= Mem_wdata;
        else if (tb_we) mem[tb_addr] <= tb_wdata;
    end

    // Reference: data bits fill non-power-of-two positions 1..15, parity bit 2^k covers positions with bit k set.
    function automatic logic [15:0] ref_enc(input logic [10:0] m);
        logic [15:0] w;
        logic        par;
        int          k;
        w = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos] = m[k];
                k++;
            end
        end
        for (int p = 0; p < 4; p++) begin
            par = 1'b0;
            for (int pos = 1; pos < 16; pos++) if (((pos >> p) & 1) == 1) par ^= w[pos];
            w[1 << p] = par;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mem_wr(input logic [7:0] addr, input logic [7:0] data);
        @(negedge Clk);
        tb_we    = 1'b1;
        tb_addr  = addr;
        tb_wdata = data;
        @(posedge Clk);
        #1 tb_we = 1'b0;
    endtask

    // mode 0: directed first four, clean random rest; mode 1: first three have high byte 0xF8|x; mode 2: fully random
    task automatic load_msgs(input int mode);
        logic [7:0] lo, hi;
        exp_bad = 0;
        for (int i = 0; i < NUM_MSG; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom_range(0, 7));
            if (mode == 0) begin
                case (i)
                    0: begin lo = 8'h00; hi = 8'h00; end
                    1: begin lo = 8'hFF; hi = 8'h07; end
                    2: begin lo = 8'h01; hi = 8'h00; end
                    3: begin lo = 8'h00; hi = 8'h04; end
                    default: ;
                endcase
            end else if (mode == 1) begin
                if (i < 3) hi = 8'hF8 | 8'($urandom_range(0, 7));
            end else begin
                hi = 8'($urandom);
            end
            if (hi[7:3] != 0 && exp_bad < 15) exp_bad++;
            src_word[i] = {hi, lo};
            mem_wr(8'(SRC_BASE + 2 * i), lo);
            mem_wr(8'(SRC_BASE + 2 * i + 1), hi);
        end
    endtask

    task automatic check_msgs(input string tag, input int first, input int last);
        logic [15:0] e;
        for (int i = first; i <= last; i++) begin
            e = ref_enc(src_word[i][10:0]);
            check($sformatf("%s_enc%0d_lo", tag, i), mem[8'(DST_BASE + 2 * i)], e[7:0]);
            check($sformatf("%s_enc%0d_hi", tag, i), mem[8'(DST_BASE + 2 * i + 1)], e[15:8]);
            check($sformatf("%s_src%0d", tag, i),
                  {mem[8'(SRC_BASE + 2 * i + 1)], mem[8'(SRC_BASE + 2 * i)]}, src_word[i]);
        end
    endtask

    // Pulses Start for one cycle, then counts edges after the sampling edge until Done.
    task automatic do_run(input string tag, input bit jitter);
        int n, busy_n;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start  = 1'b0;
        n      = 0;
        busy_n = Busy ? 1 : 0;
        while (!Done && n < 200) begin
            if (jitter) Start = 1'($urandom);
            @(posedge Clk);
            @(negedge Clk);
            n++;
            if (Busy) busy_n++;
        end
        Start = 1'b0;
        check({tag, "_latency"}, n, 4 * NUM_MSG);
        check({tag, "_busy_cycles"}, busy_n, 4 * NUM_MSG);
    endtask

    initial begin
        int n;
        Reset = 1'b1;
        Start = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        #2;
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_we", Mem_we, 1'b0);
        check("rst_addr", Mem_addr, '0);
        check("rst_wdata", Mem_wdata, '0);
`ifdef HAMMING_ENC_SEQ_BADIN_EN
        check("rst_bad", Bad_cnt, 4'd0);
`endif
        @(negedge Clk);
        Reset = 1'b0;

        // Directed corner messages plus clean random ones
        load_msgs(0);
        do_run("run0", 1'b0);
        check_msgs("run0", 0, NUM_MSG - 1);
        check("zero_lo", mem[30], 8'h00);
        check("zero_hi", mem[31], 8'h00);
        check("ones_lo", mem[32], 8'hFF);
        check("ones_hi", mem[33], 8'hFF);
        check("d001_lo", mem[34], 8'h0F);
        check("d001_hi", mem[35], 8'h00);
        check("d400_lo", mem[36], 8'h17);
        check("d400_hi", mem[37], 8'h81);
`ifdef HAMMING_ENC_SEQ_BADIN_EN
        check("run0_bad", Bad_cnt, 32'(exp_bad));
`endif
        repeat (3) @(negedge Clk);
        check("done_held", Done, 1'b1);
        check("done_we", Mem_we, 1'b0);
        check("done_busy", Busy, 1'b0);

        // Reset during message 7 WR_LO, then a full clean rerun
        load_msgs(1);
        for (int a = DST_BASE; a < DST_BASE + 2 * NUM_MSG; a++) mem_wr(8'(a), 8'hAA);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (30) @(posedge Clk);
        @(negedge Clk);
        check("mid_we_before", Mem_we, 1'b1);
        check("mid_addr_before", Mem_addr, 8'(DST_BASE + 14));
        #1 Reset = 1'b1;
        #1;
        check("mid_we", Mem_we, 1'b0);
        check("mid_busy", Busy, 1'b0);
        check("mid_done", Done, 1'b0);
        @(negedge Clk);
        check_msgs("mid_kept", 0, 6);
        check("mid_unwritten", mem[8'(DST_BASE + 14)], 8'hAA);
        Reset = 1'b0;
        do_run("rerun", 1'b0);
        check_msgs("rerun", 0, NUM_MSG - 1);
`ifdef HAMMING_ENC_SEQ_BADIN_EN
        check("rerun_bad", Bad_cnt, 32'(exp_bad));
        check("rerun_bad3", Bad_cnt, 4'd3);
`endif

        // Fully random source with junk high bits, Start toggled while Busy
        load_msgs(2);
        do_run("jitter", 1'b1);
        check_msgs("jitter", 0, NUM_MSG - 1);
`ifdef HAMMING_ENC_SEQ_BADIN_EN
        check("jitter_bad", Bad_cnt, 32'(exp_bad));
`endif

        // Start held high: back-to-back runs with a single Done cycle between them
        for (int a = DST_BASE; a < DST_BASE + 2 * NUM_MSG; a++) mem_wr(8'(a), 8'h55);
        @(negedge Clk);
        Start = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(posedge Clk);
            @(negedge Clk);
            check($sformatf("held%0d_busy_first", r), Busy, 1'b1);
            check($sformatf("held%0d_done_first", r), Done, 1'b0);
            n = 0;
            while (!Done && n < 200) begin
                @(posedge Clk);
                @(negedge Clk);
                n++;
            end
            check($sformatf("held%0d_latency", r), n, 4 * NUM_MSG);
        end
        Start = 1'b0;
        @(negedge Clk);
        check("held_done_stays", Done, 1'b1);
        check_msgs("held", 0, NUM_MSG - 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
